// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory subsystem.
// Holds the memory-map constants, the region type and the address decoder
// that the top level uses to route CPU reads and writes.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE    = 15'h0000;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_t;

  // Map a 15-bit data address onto its region. Everything above KBD_ADDR is unmapped.
  function automatic region_t decode(input logic [14:0] addr);
    if (addr < SCREEN_BASE)   return REG_RAM;
    else if (addr < KBD_ADDR) return REG_SCREEN;
    else if (addr == KBD_ADDR) return REG_KBD;
    else                      return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_kbd_fifo.sv
// Synchronous key-code FIFO feeding the Hack KBD register.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   push_valid/push_data  push request and word
//   push_ready            room available, or full with a pop in the same cycle
//   pop                   pop strobe; ignored when empty
//   head                  word at the read pointer (meaningful only when !empty)
//   empty, full           occupancy flags
module hack_kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_eff;
  logic             push_eff;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  // A pop on an empty FIFO does nothing, so it must not open a slot either.
  assign pop_eff    = pop && !empty;
  assign push_ready = !full || pop_eff;
  assign push_eff   = push_valid && push_ready;
  assign head       = mem[rd_ptr_reg];

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data-memory subsystem: RAM, SCREEN and KBD behind one 15-bit word space.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   address/outM/writeM        CPU data bus; writes land on the rising edge
//   inM                        combinational read data for address
//   key_valid/key_code/key_ready  key-code push port into the KBD FIFO
//   scr_rd_addr/scr_rd_data    video scan port, one-cycle registered read
//   bad_access/bad_addr        illegal-write trap (only with HACK_MEM_TRAP_EN)
// Build option: define HACK_MEM_TRAP_EN to enable the unmapped-write trap;
// otherwise bad_access and bad_addr are tied to zero.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS      = 16384,
  parameter int SCREEN_WORDS   = 8192,
  parameter int KBD_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [14:0]                     address,
  input  logic [15:0]                     outM,
  input  logic                            writeM,
  output logic [15:0]                     inM,
  input  logic                            key_valid,
  input  logic [15:0]                     key_code,
  output logic                            key_ready,
  input  logic [$clog2(SCREEN_WORDS)-1:0] scr_rd_addr,
  output logic [15:0]                     scr_rd_data,
  output logic                            bad_access,
  output logic [14:0]                     bad_addr
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];

  region_t           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic              wr_en;
  logic              kbd_pop;
  logic [15:0]       kbd_head;
  logic              kbd_empty;
  logic              kbd_full;

  assign region  = decode(address);
  assign ram_idx = RAM_AW'(address - RAM_BASE);
  assign scr_idx = SCR_AW'(address - SCREEN_BASE);
  // A write that coincides with reset being held is dropped.
  assign wr_en   = writeM && reset_n;
  assign kbd_pop = wr_en && (region == REG_KBD);

  always_ff @(posedge clk) begin
    if (wr_en && region == REG_RAM) ram[ram_idx] <= outM;
  end

  always_ff @(posedge clk) begin
    if (wr_en && region == REG_SCREEN) screen[scr_idx] <= outM;
  end

  // Video read samples the array before any same-edge CPU write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scr_rd_data <= '0;
    else          scr_rd_data <= screen[scr_rd_addr];
  end

  // Zero means "no key", so zero codes are never enqueued.
  hack_kbd_fifo #(
    .DEPTH (KBD_FIFO_DEPTH),
    .WIDTH (16)
  ) u_kbd_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (key_valid && (key_code != 16'h0000)),
    .push_data  (key_code),
    .push_ready (key_ready),
    .pop        (kbd_pop),
    .head       (kbd_head),
    .empty      (kbd_empty),
    .full       (kbd_full)
  );

  always_comb begin
    inM = 16'h0000;
    case (region)
      REG_RAM:    inM = ram[ram_idx];
      REG_SCREEN: inM = screen[scr_idx];
      REG_KBD:    inM = kbd_empty ? 16'h0000 : kbd_head;
      default:    inM = 16'h0000;
    endcase
  end

`ifdef HACK_MEM_TRAP_EN
  logic        bad_access_reg;
  logic [14:0] bad_addr_reg;

  // Only the first illegal write is captured; the flag is sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_access_reg <= 1'b0;
      bad_addr_reg   <= '0;
    end else if (writeM && region == REG_NONE && !bad_access_reg) begin
      bad_access_reg <= 1'b1;
      bad_addr_reg   <= address;
    end
  end

  assign bad_access = bad_access_reg;
  assign bad_addr   = bad_addr_reg;
`else
  assign bad_access = 1'b0;
  assign bad_addr   = '0;
`endif

  // kbd_full is only of interest for debug visibility.
  logic unused_ok;
  assign unused_ok = kbd_full;

endmodule

// File: tb/tb_hack_data_memory.sv
module tb_hack_data_memory;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] address = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic        key_valid = 1'b0;
  logic [15:0] key_code = '0;
  logic        key_ready;
  logic [12:0] scr_rd_addr = '0;
  logic [15:0] scr_rd_data;
  logic        bad_access;
  logic [14:0] bad_addr;

  always #5 clk = ~clk;

  hack_data_memory dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .outM        (outM),
    .writeM      (writeM),
    .inM         (inM),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .scr_rd_addr (scr_rd_addr),
    .scr_rd_data (scr_rd_data),
    .bad_access  (bad_access),
    .bad_addr    (bad_addr)
  );

  // Scoreboard entry: which output to sample in which cycle, and its expected value.
  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sparse word memory, key queue, trap state.
  logic [15:0] mem_m [int];
  logic [15:0] kq[$];
  bit          bad_m = 1'b0;
  logic [14:0] bad_addr_m = '0;
  bit          scr_pend_valid = 1'b0;
  logic [15:0] scr_pend_exp = '0;

  function automatic void push_chk(int c, int s, logic [15:0] e, string n);
    chk_t t;
    t.cyc = c; t.sig = s; t.exp = e; t.name = n;
    sb.push_back(t);
  endfunction

  function automatic void push_trap_chk(int c);
`ifdef HACK_MEM_TRAP_EN
    push_chk(c, 3, {15'h0, bad_m}, "bad_access");
    push_chk(c, 4, {1'b0, bad_addr_m}, "bad_addr");
`else
    push_chk(c, 3, 16'h0, "bad_access");
    push_chk(c, 4, 16'h0, "bad_addr");
`endif
  endfunction

  // Monitor: compares every scoreboard entry due in the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk_t e;
        logic [15:0] act;
        e = sb.pop_front();
        case (e.sig)
          0:       act = inM;
          1:       act = {15'h0, key_ready};
          2:       act = scr_rd_data;
          3:       act = {15'h0, bad_access};
          default: act = {1'b0, bad_addr};
        endcase
        checks++;
        if (e.cyc != cyc)
          $display("FAIL %s stale check: due cycle %0d, now cycle %0d", e.name, e.cyc, cyc);
        else if (act === e.exp) begin
          passed++;
          $display("cyc %0d %s ok: %h", cyc, e.name, act);
        end else
          $display("FAIL %s cyc=%0d actual=%h expected=%h", e.name, cyc, act, e.exp);
      end
    end
  end

  // One CPU/key/video transaction per call; entered and left at posedge+1.
  task automatic cycle(input logic [14:0] a, input logic [15:0] d, input bit wr,
                       input bit kv, input logic [15:0] kc, input logic [12:0] sa);
    bit rdy;
    int ia;
    address = a; outM = d; writeM = wr; key_valid = kv; key_code = kc; scr_rd_addr = sa;
    ia = int'(a);
    if (ia < 'h6000) begin
      if (mem_m.exists(ia)) push_chk(cyc, 0, mem_m[ia], "inM_mem");
    end else if (ia == 'h6000) begin
      push_chk(cyc, 0, (kq.size() > 0) ? kq[0] : 16'h0, "inM_kbd");
    end else begin
      push_chk(cyc, 0, 16'h0, "inM_unmapped");
    end
    rdy = (kq.size() < DEPTH) || (wr && ia == 'h6000 && kq.size() > 0);
    push_chk(cyc, 1, {15'h0, rdy}, "key_ready");
    if (scr_pend_valid) push_chk(cyc, 2, scr_pend_exp, "scr_rd_data");
    push_trap_chk(cyc);
    // Video sees the contents before this cycle's write (read-before-write).
    scr_pend_valid = mem_m.exists('h4000 + int'(sa));
    if (scr_pend_valid) scr_pend_exp = mem_m['h4000 + int'(sa)];
    @(posedge clk); #1;
    if (wr && ia == 'h6000 && kq.size() > 0) void'(kq.pop_front());
    if (kv && rdy && kc != 16'h0) begin
      if (kq.size() < DEPTH) kq.push_back(kc);
    end
    if (wr && ia < 'h6000) mem_m[ia] = d;
    if (wr && ia > 'h6000 && !bad_m) begin
      bad_m = 1'b1;
      bad_addr_m = a;
    end
  endtask

  task automatic do_reset();
    writeM = 1'b0; key_valid = 1'b0; address = 15'h6000;
    reset_n = 1'b0;
    kq.delete();
    bad_m = 1'b0; bad_addr_m = '0;
    push_chk(cyc, 0, 16'h0, "rst_inM_kbd");
    push_chk(cyc, 1, 16'h1, "rst_key_ready");
    push_chk(cyc, 2, 16'h0, "rst_scr_rd_data");
    push_chk(cyc, 3, 16'h0, "rst_bad_access");
    push_chk(cyc, 4, 16'h0, "rst_bad_addr");
    @(posedge clk); #1;
    reset_n = 1'b1;
    scr_pend_valid = 1'b1;
    scr_pend_exp = 16'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // RAM write/read, neighbour untouched
    cycle(15'd6, 16'd777, 1, 0, 0, 0);
    cycle(15'd5, 16'd123, 1, 0, 0, 0);
    cycle(15'd5, 16'd0,   0, 0, 0, 0);
    cycle(15'd6, 16'd0,   0, 0, 0, 0);

    // SCREEN write, video readback, read-before-write
    cycle(15'h4000, 16'hFFFF, 1, 0, 0, 13'd0);
    cycle(15'h4000, 16'h0,    0, 0, 0, 13'd0);
    cycle(15'h4000, 16'h0,    0, 0, 0, 13'd0);
    cycle(15'h4001, 16'hAAAA, 1, 0, 0, 13'd1);
    cycle(15'h4001, 16'h5555, 1, 0, 0, 13'd1);
    cycle(15'h4001, 16'h0,    0, 0, 0, 13'd1);
    cycle(15'h4001, 16'h0,    0, 0, 0, 13'd1);

    // KBD pops
    cycle(15'd0, 0, 0, 1, 16'h41, 0);
    cycle(15'd0, 0, 0, 1, 16'h42, 0);
    cycle(15'h6000, 0, 0, 0, 0, 0);
    cycle(15'h6000, 0, 1, 0, 0, 0);
    cycle(15'h6000, 0, 1, 0, 0, 0);
    cycle(15'h6000, 0, 1, 0, 0, 0);
    cycle(15'h6000, 0, 0, 0, 0, 0);

    // Zero code dropped; push+pop on empty
    cycle(15'h6000, 0, 0, 1, 16'h0, 0);
    cycle(15'h6000, 0, 1, 1, 16'h9, 0);
    cycle(15'h6000, 0, 1, 0, 0, 0);
    cycle(15'h6000, 0, 0, 0, 0, 0);

    // Fill past depth, push+pop on full, drain
    for (int i = 1; i <= 5; i++) cycle(15'd0, 0, 0, 1, 16'(i), 0);
    cycle(15'h6000, 0, 1, 1, 16'h6, 0);
    for (int i = 0; i < 5; i++) cycle(15'h6000, 0, 1, 0, 0, 0);

    // Reset with keys queued; RAM contents survive
    for (int i = 0; i < 3; i++) cycle(15'd0, 0, 0, 1, 16'h70 + 16'(i), 0);
    do_reset();
    cycle(15'd5, 0, 0, 0, 0, 0);
    cycle(15'h6000, 0, 0, 0, 0, 0);

    // Unmapped writes
    cycle(15'h6001, 16'h1, 1, 0, 0, 0);
    cycle(15'h7FFF, 16'h2, 1, 0, 0, 0);
    cycle(15'h6001, 16'h0, 0, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      logic [14:0] a;
      logic [15:0] kc;
      int sel;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0, 4:    a = 15'($urandom_range(0, 15));
        1:       a = 15'('h4000 + $urandom_range(0, 15));
        2:       a = 15'h6000;
        default: a = 15'($urandom_range('h6001, 'h7FFF));
      endcase
      kc = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      cycle(a, 16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            kc, 13'($urandom_range(0, 15)));
    end

    cycle(15'd0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
